// File: rtl/sorted_triple_serializer.sv
// sorted_triple_serializer
//
// Takes one descending-sorted triple (no1 >= no2 >= no3) per valid/ready
// transfer and replays it as three single-word beats on a valid/ready
// stream, largest word first. Each triple's sort order is checked on
// entry: the result is tagged onto every beat of that triple and also
// latched into a sticky flag. Triples whose last beat has been accepted
// downstream are counted.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready input handshake, one triple per transfer
//   in_no1..in_no3    triple words, largest first
//   out_valid/out_ready output handshake, one word per beat
//   out_data          current word
//   out_idx           position of out_data in its triple (0..2)
//   out_last          high on the third beat
//   out_err           current triple failed the order check
//   err_sticky        any accepted triple failed the check since reset
//   triple_cnt        completed triples, wraps silently
module sorted_triple_serializer #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_no1,
  input  logic [WIDTH-1:0] in_no2,
  input  logic [WIDTH-1:0] in_no3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             out_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] triple_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    W2   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf1_q, buf2_q, buf3_q;
  logic             buf_err_q;
  logic             err_sticky_q;
  logic [CNT_W-1:0] triple_cnt_q;

  logic accept;
  logic order_bad;
  logic last_done;

  // Ready while empty, or while the final beat is leaving this cycle so a
  // new triple can follow without a bubble. Deliberately independent of
  // in_valid.
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == W2) && out_ready));
  assign accept    = in_valid && in_ready;
  assign order_bad = (in_no1 < in_no2) || (in_no2 < in_no3);
  assign last_done = (state_q == W2) && out_ready;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = W0;
      W0:   if (out_ready) state_d = W1;
      W1:   if (out_ready) state_d = W2;
      W2:   if (out_ready) state_d = accept ? W0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything is a function of registered state, so the
  // beat stays stable while the sink stalls.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = 2'd0;
    out_last  = 1'b0;
    out_err   = 1'b0;
    case (state_q)
      W0: begin
        out_valid = 1'b1;
        out_data  = buf1_q;
        out_idx   = 2'd0;
        out_err   = buf_err_q;
      end
      W1: begin
        out_valid = 1'b1;
        out_data  = buf2_q;
        out_idx   = 2'd1;
        out_err   = buf_err_q;
      end
      W2: begin
        out_valid = 1'b1;
        out_data  = buf3_q;
        out_idx   = 2'd2;
        out_last  = 1'b1;
        out_err   = buf_err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      buf1_q       <= '0;
      buf2_q       <= '0;
      buf3_q       <= '0;
      buf_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      triple_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        buf1_q       <= in_no1;
        buf2_q       <= in_no2;
        buf3_q       <= in_no3;
        buf_err_q    <= order_bad;
        err_sticky_q <= err_sticky_q | order_bad;
      end
      if (last_done) begin
        triple_cnt_q <= triple_cnt_q + CNT_W'(1);
      end
    end
  end

  assign err_sticky = err_sticky_q;
  assign triple_cnt = triple_cnt_q;

endmodule

// File: tb/tb_sorted_triple_serializer.sv
module tb_sorted_triple_serializer;

  localparam int W  = 3;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_no1, in_no2, in_no3;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_idx;
  logic          out_last;
  logic          out_err;
  logic          err_sticky;
  logic [CW-1:0] triple_cnt;

  sorted_triple_serializer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_no1     (in_no1),
    .in_no2     (in_no2),
    .in_no3     (in_no3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .triple_cnt (triple_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a queue of words still owed downstream.
  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   idx;
    bit           err;
  } beat_t;

  beat_t q[$];
  int    m_cnt;
  bit    m_sticky;
  bit    exp_err_in;
  bit    accepted;
  int    n_checks;
  int    n_fail;
  int    n_acc;

  typedef struct {
    logic [W-1:0] n1, n2, n3;
    bit           err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: entered at posedge+1 with inputs driven; compares at
  // the negedge, advances the model, returns at the next posedge+1.
  task automatic step();
    bit    v, rdy;
    beat_t b;
    logic [CW-1:0] ec;
    @(negedge clk);
    v   = (q.size() != 0);
    rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
    ec  = m_cnt[CW-1:0];
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (v) begin
      b = q[0];
      chk("out_data", 32'(out_data), 32'(b.d));
      chk("out_idx", 32'(out_idx), 32'(b.idx));
      chk("out_last", 32'(out_last), 32'(b.idx == 2'd2));
      chk("out_err", 32'(out_err), 32'(b.err));
    end else begin
      chk("idle_data", 32'(out_data), 32'd0);
      chk("idle_last", 32'(out_last), 32'd0);
      chk("idle_err", 32'(out_err), 32'd0);
    end
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("triple_cnt", 32'(triple_cnt), 32'(ec));
    accepted = 1'b0;
    if (v && out_ready) begin
      if (q[0].idx == 2'd2) m_cnt++;
      void'(q.pop_front());
    end
    if (in_valid && rdy) begin
      q.push_back('{d: in_no1, idx: 2'd0, err: exp_err_in});
      q.push_back('{d: in_no2, idx: 2'd1, err: exp_err_in});
      q.push_back('{d: in_no3, idx: 2'd2, err: exp_err_in});
      m_sticky = m_sticky | exp_err_in;
      accepted = 1'b1;
      n_acc++;
      $display("accept #%0d: %0d %0d %0d err=%0d", n_acc, in_no1, in_no2, in_no3, exp_err_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int ncyc);
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_cnt", 32'(triple_cnt), 32'd0);
    q.delete();
    m_cnt = 0;
    m_sticky = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, bit e);
    int i;
    in_valid = 1'b1;
    in_no1 = a; in_no2 = b; in_no3 = c;
    exp_err_in = e;
    out_ready = 1'b1;
    i = 0;
    accepted = 1'b0;
    while (!accepted && i < 20) begin
      step();
      i++;
    end
    if (!accepted) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(int max);
    int i;
    in_valid = 1'b0;
    out_ready = 1'b1;
    i = 0;
    while (q.size() != 0 && i < max) begin
      step();
      i++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int gap;
    n_checks = 0; n_fail = 0; n_acc = 0;
    m_cnt = 0; m_sticky = 1'b0; exp_err_in = 1'b0; accepted = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_no1 = '0; in_no2 = '0; in_no3 = '0;

    tbl[0] = '{n1: 3'd0, n2: 3'd0, n3: 3'd0, err: 1'b0};
    tbl[1] = '{n1: 3'd7, n2: 3'd7, n3: 3'd7, err: 1'b0};
    tbl[2] = '{n1: 3'd7, n2: 3'd0, n3: 3'd0, err: 1'b0};
    tbl[3] = '{n1: 3'd6, n2: 3'd3, n3: 3'd1, err: 1'b0};
    tbl[4] = '{n1: 3'd0, n2: 3'd7, n3: 3'd0, err: 1'b1};
    tbl[5] = '{n1: 3'd3, n2: 3'd4, n3: 3'd4, err: 1'b1};
    tbl[6] = '{n1: 3'd5, n2: 3'd5, n3: 3'd6, err: 1'b1};
    tbl[7] = '{n1: 3'd2, n2: 3'd1, n3: 3'd2, err: 1'b1};

    @(posedge clk); #1;
    do_reset(2);
    step();
    step();

    // Reset held two cycles while idle
    do_reset(2);
    step();

    // Single triple 6,4,1
    send(3'd6, 3'd4, 3'd1, 1'b0);
    drain(10);
    chk("cnt_single", 32'(triple_cnt), 32'd1);

    // Back-to-back 7,7,3 then 5,2,0 with in_valid held
    send(3'd7, 3'd7, 3'd3, 1'b0);
    in_valid = 1'b1;
    in_no1 = 3'd5; in_no2 = 3'd2; in_no3 = 3'd0;
    exp_err_in = 1'b0;
    gap = 0;
    accepted = 1'b0;
    while (!accepted && gap < 10) begin
      step();
      gap++;
    end
    chk("b2b_accept_gap", 32'(gap), 32'd3);
    drain(10);
    chk("cnt_b2b", 32'(triple_cnt), 32'd3);

    // Backpressure on the idx 1 beat of 4,3,2
    send(3'd4, 3'd3, 3'd2, 1'b0);
    step();
    out_ready = 1'b0;
    step();
    chk("bp_hold_data", 32'(out_data), 32'd3);
    step();
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    drain(10);
    chk("cnt_wrap_bp", 32'(triple_cnt), 32'd0);

    // Order error, then a good triple
    send(3'd2, 3'd5, 3'd1, 1'b1);
    drain(10);
    chk("sticky_set", 32'(err_sticky), 32'd1);
    send(3'd3, 3'd2, 3'd1, 1'b0);
    drain(10);
    chk("sticky_stays", 32'(err_sticky), 32'd1);

    // Reset during the idx 1 beat of 6,5,4
    do_reset(1);
    send(3'd6, 3'd5, 3'd4, 1'b0);
    step();
    chk("pre_rst_idx", 32'(out_idx), 32'd1);
    do_reset(1);
    repeat (3) step();
    chk("cnt_after_mid_rst", 32'(triple_cnt), 32'd0);

    // Counter wrap with four triples
    for (int i = 0; i < 3; i++) send(3'd5, 3'd3, 3'd1, 1'b0);
    drain(20);
    chk("cnt_three", 32'(triple_cnt), 32'd3);
    send(3'd1, 3'd1, 3'd0, 1'b0);
    drain(10);
    chk("cnt_wrap", 32'(triple_cnt), 32'd0);

    // Table-driven vectors, queued back-to-back
    do_reset(1);
    for (int i = 0; i < 8; i++) send(tbl[i].n1, tbl[i].n2, tbl[i].n3, tbl[i].err);
    drain(20);

    // Randomized traffic with random backpressure
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_no1 = W'($urandom_range(0, 7));
      in_no2 = W'($urandom_range(0, 7));
      in_no3 = W'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        // bias toward well-ordered triples
        in_no2 = (in_no2 > in_no1) ? in_no1 : in_no2;
        in_no3 = (in_no3 > in_no2) ? in_no2 : in_no3;
      end
      exp_err_in = (int'(in_no1) < int'(in_no2)) || (int'(in_no2) < int'(in_no3));
      step();
    end
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
